// File: rtl/count_disp_pkg.sv
// count_disp_pkg: shared definitions for the counter BCD display block.
// Holds the conversion FSM state encoding, the seven-segment codes
// (gfedcba, active-high), the anode select codes and the add-3 helper
// used by the double-dabble engine.
package count_disp_pkg;

    // Conversion FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Segment codes, bit0 = a ... bit6 = g.
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Digit enables, active-high.
    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;

    // Double-dabble correction: a BCD nibble of 5 or more gets +3 before
    // the shift so that it carries correctly into the next decade.
    function automatic logic [3:0] add3(input logic [3:0] nib);
        logic [3:0] res;
        res = (nib >= 4'd5) ? (nib + 4'd3) : nib;
        return res;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational BCD digit to seven-segment decoder.
// Output is active-high, bit0 = a ... bit6 = g. Non-decimal inputs
// (10..15) produce a blank pattern.
module seg7_dec
    import count_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Table lookup from digit to segment pattern.
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display: samples the mod-21 event counter on a strobe, converts
// it to two BCD digits with a sequential shift-add-3 engine (IN_W shift
// cycles) and time-multiplexes the digits onto a 2-digit common-cathode
// seven-segment display.
//
// Handshake: q_in is captured on the posedge where q_vld=1 and the FSM is
// in IDLE; there is no ready output, the strobe is simply ignored while a
// conversion is running or finishing. busy is high from the capture edge
// until the FSM enters DONE; done pulses for one cycle in the cycle where
// bcd_tens/bcd_ones first show the new result.
//
// Optional build macro COUNT_BCD_PENDING_EN: adds a one-deep pending slot
// so that a strobe arriving while not IDLE is remembered (latest wins) and
// started straight from DONE.
module count_bcd_display
    import count_disp_pkg::*;
#(
    parameter int IN_W        = 5,
    parameter int REFRESH_DIV = 4
) (
    input  logic            ck,
    input  logic            rs,
    input  logic [IN_W-1:0] q_in,
    input  logic            q_vld,
    output logic            busy,
    output logic            done,
    output logic [3:0]      bcd_tens,
    output logic [3:0]      bcd_ones,
    output logic [6:0]      seg,
    output logic [1:0]      an,
    output logic [1:0]      dbg_state
);

    localparam int CNT_W = $clog2(IN_W + 1);
    localparam int RF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int CAT_W = 8 + IN_W;

    // ------------------------------------------------------------------
    // Conversion state
    // ------------------------------------------------------------------
    state_e            state_q;
    logic              busy_q;
    logic              done_q;
    logic [3:0]        tens_q;
    logic [3:0]        ones_q;
    logic [IN_W-1:0]   sh_q;
    logic [7:0]        scr_q;
    logic [CNT_W-1:0]  cnt_q;

`ifdef COUNT_BCD_PENDING_EN
    logic              pend_v_q;
    logic [IN_W-1:0]   pend_q;
`endif

    // Combinational double-dabble step
    logic [7:0]        scr_adj;
    logic [CAT_W-1:0]  cat_adj;
    logic [CAT_W-1:0]  cat_shl;
    logic [7:0]        scr_nxt;
    logic [IN_W-1:0]   sh_nxt;

    // Add-3 correction on both scratch nibbles, then shift {scratch, shift}
    // left by one. The concatenation is rotated rather than shifted: its
    // MSB is always zero (a 5-bit value never needs more than 8 BCD bits),
    // so the rotate brings a zero into the shift register LSB and keeps
    // every bit of the vector in use.
    always_comb begin
        scr_adj = {add3(scr_q[7:4]), add3(scr_q[3:0])};
        cat_adj = {scr_adj, sh_q};
        cat_shl = {cat_adj[CAT_W-2:0], cat_adj[CAT_W-1]};
        scr_nxt = cat_shl[CAT_W-1:IN_W];
        sh_nxt  = cat_shl[IN_W-1:0];
    end

    // Conversion FSM with registered busy/done/digit outputs.
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            sh_q     <= '0;
            scr_q    <= 8'd0;
            cnt_q    <= '0;
`ifdef COUNT_BCD_PENDING_EN
            pend_v_q <= 1'b0;
            pend_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (q_vld) begin
                        sh_q    <= q_in;
                        scr_q   <= 8'd0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    scr_q <= scr_nxt;
                    sh_q  <= sh_nxt;
                    if (cnt_q == CNT_W'(IN_W - 1)) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`ifdef COUNT_BCD_PENDING_EN
                    // Remember the latest strobe seen while converting.
                    if (q_vld) begin
                        pend_v_q <= 1'b1;
                        pend_q   <= q_in;
                    end
`endif
                end

                ST_DONE: begin
                    tens_q  <= scr_q[7:4];
                    ones_q  <= scr_q[3:0];
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
`ifdef COUNT_BCD_PENDING_EN
                    // A strobe in this very cycle is newer than the slot.
                    if (q_vld || pend_v_q) begin
                        sh_q     <= q_vld ? q_in : pend_q;
                        scr_q    <= 8'd0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        pend_v_q <= 1'b0;
                        state_q  <= ST_SHIFT;
                    end
`endif
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bcd_tens  = tens_q;
    assign bcd_ones  = ones_q;
    assign dbg_state = state_q;

    // ------------------------------------------------------------------
    // Display multiplexer
    // ------------------------------------------------------------------
    logic [RF_W-1:0] rf_q;
    logic [RF_W-1:0] rf_d;
    logic [1:0]      an_q;
    logic [1:0]      an_d;
    logic [6:0]      seg_q;
    logic [6:0]      seg_d;
    logic [3:0]      tens_nxt;
    logic [3:0]      ones_nxt;
    logic [3:0]      mux_digit;
    logic [6:0]      dec_seg;

    // Refresh counter and anode toggle on wrap. The segment register is
    // fed from the next-cycle anode and digit values so that seg and an
    // always describe the same digit, including right after a conversion.
    always_comb begin
        rf_d = rf_q + RF_W'(1);
        an_d = an_q;
        if (rf_q == RF_W'(REFRESH_DIV - 1)) begin
            rf_d = '0;
            an_d = (an_q == AN_ONES) ? AN_TENS : AN_ONES;
        end

        tens_nxt = (state_q == ST_DONE) ? scr_q[7:4] : tens_q;
        ones_nxt = (state_q == ST_DONE) ? scr_q[3:0] : ones_q;

        mux_digit = (an_d == AN_TENS) ? tens_nxt : ones_nxt;

        // Leading-zero blanking on the tens position.
        if ((an_d == AN_TENS) && (tens_nxt == 4'd0)) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = dec_seg;
        end
    end

    seg7_dec u_seg7_dec (
        .digit (mux_digit),
        .seg   (dec_seg)
    );

    // Display registers: refresh counter, anode select, segment pattern.
    always_ff @(posedge ck or posedge rs) begin
        if (rs) begin
            rf_q  <= '0;
            an_q  <= AN_ONES;
            seg_q <= SEG_BLANK;
        end else begin
            rf_q  <= rf_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// tb_count_bcd_display: self-checking bench for count_bcd_display.
// A cycle-level reference model (integer division for the digits, elapsed
// cycle count for the display phase) predicts every output after each
// posedge; all comparisons go through check_eq.
module tb_count_bcd_display;

    localparam int IN_W        = 5;
    localparam int REFRESH_DIV = 4;
    localparam int LATENCY     = IN_W + 1;

    logic            ck;
    logic            rs;
    logic [IN_W-1:0] q_in;
    logic            q_vld;
    logic            busy;
    logic            done;
    logic [3:0]      bcd_tens;
    logic [3:0]      bcd_ones;
    logic [6:0]      seg;
    logic [1:0]      an;
    logic [1:0]      dbg_state;

    count_bcd_display #(
        .IN_W        (IN_W),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .ck        (ck),
        .rs        (rs),
        .q_in      (q_in),
        .q_vld     (q_vld),
        .busy      (busy),
        .done      (done),
        .bcd_tens  (bcd_tens),
        .bcd_ones  (bcd_ones),
        .seg       (seg),
        .an        (an),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial ck = 1'b0;
    always #5 ck = ~ck;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [6:0] seg_tab [0:9];
    int  k;           // posedges since reset release
    bit  in_flight;
    int  done_edge;   // edge at which the running conversion completes
    int  cur_val;
    int  m_tens;
    int  m_ones;
    bit  m_done;
    bit  pend_v;
    int  pend_val;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_an();
        return (((k / REFRESH_DIV) % 2) == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [6:0] exp_seg();
        logic [6:0] r;
        if (k == 0) begin
            r = 7'b0000000;
        end else if (exp_an() == 2'b10) begin
            r = (m_tens == 0) ? 7'b0000000 : seg_tab[m_tens];
        end else begin
            r = seg_tab[m_ones];
        end
        return r;
    endfunction

    task automatic check_all();
        logic exp_busy;
        exp_busy = in_flight && (k < done_edge - 1);
        check_eq("busy", 8'(busy), 8'(exp_busy));
        check_eq("done", 8'(done), 8'(m_done));
        check_eq("bcd_tens", 8'(bcd_tens), 8'(m_tens));
        check_eq("bcd_ones", 8'(bcd_ones), 8'(m_ones));
        check_eq("an", 8'(an), 8'(exp_an()));
        check_eq("seg", 8'(seg), 8'(exp_seg()));
    endtask

    task automatic start_conv(input int v);
        in_flight = 1'b1;
        cur_val   = v;
        done_edge = k + LATENCY;
    endtask

    // Driver: apply inputs, advance one clock, update the model, check.
    task automatic step(input bit vld, input int val);
        q_vld = vld;
        q_in  = val[IN_W-1:0];
        @(posedge ck);
        if (!rs) begin
            k++;
            m_done = 1'b0;
            if (in_flight && k == done_edge) begin
                m_tens    = cur_val / 10;
                m_ones    = cur_val % 10;
                m_done    = 1'b1;
                in_flight = 1'b0;
`ifdef COUNT_BCD_PENDING_EN
                if (vld) begin
                    start_conv(val);
                    pend_v = 1'b0;
                end else if (pend_v) begin
                    start_conv(pend_val);
                    pend_v = 1'b0;
                end
`endif
            end else if (vld) begin
                if (!in_flight) start_conv(val);
`ifdef COUNT_BCD_PENDING_EN
                else begin
                    pend_v   = 1'b1;
                    pend_val = val;
                end
`endif
            end
        end
        #1;
        check_all();
    endtask

    // Asynchronous reset, asserted mid-cycle, held for one edge.
    task automatic do_reset();
        rs        = 1'b1;
        q_vld     = 1'b0;
        q_in      = '0;
        k         = 0;
        in_flight = 1'b0;
        done_edge = -100;
        cur_val   = 0;
        m_tens    = 0;
        m_ones    = 0;
        m_done    = 1'b0;
        pend_v    = 1'b0;
        pend_val  = 0;
        #1;
        check_all();
        @(posedge ck);
        #1;
        check_all();
        rs = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && (in_flight || pend_v); i++) step(1'b0, 0);
    endtask

    initial begin
        seg_tab[0] = 7'b0111111;
        seg_tab[1] = 7'b0000110;
        seg_tab[2] = 7'b1011011;
        seg_tab[3] = 7'b1001111;
        seg_tab[4] = 7'b1100110;
        seg_tab[5] = 7'b1101101;
        seg_tab[6] = 7'b1111101;
        seg_tab[7] = 7'b0000111;
        seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1101111;

        // Reset state and idle refresh pattern
        do_reset();
        repeat (12) step(1'b0, 0);

        // Max counter value, both display phases
        step(1'b1, 20);
        wait_idle();
        repeat (9) step(1'b0, 0);

        // Single digit with tens blanking
        step(1'b1, 9);
        wait_idle();
        repeat (9) step(1'b0, 0);

        // Overlapping strobes
        step(1'b1, 5);
        step(1'b0, 0);
        step(1'b1, 12);
        wait_idle();
        repeat (4) step(1'b0, 0);

        // Reset in the middle of a conversion
        do_reset();
        step(1'b1, 17);
        step(1'b0, 0);
        do_reset();
        repeat (10) step(1'b0, 0);

        // Range sweep 0..31
        for (int v = 0; v < 32; v++) begin
            step(1'b1, v);
            wait_idle();
        end

        // Random strobes at random spacing
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 31)));
        end
        wait_idle();
        repeat (8) step(1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/count_bcd_display.md
Name: count_bcd_display

Overview:
- Downstream consumer of the 5-bit mod-21 event counter.
- Samples the counter value on a strobe and converts it to two BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 2-digit common-cathode seven-segment display.
- Sits between the counter and the board display pins.

Parameters:
- IN_W, 5, width of counter input; conversion takes IN_W shift cycles.
- REFRESH_DIV, 4, ck cycles each digit is driven before the mux switches (>=2).

Ports:
- ck  in  1  clock; all state updates on posedge ck (counter updates on negedge, giving half-cycle setup margin).
- rs  in  1  reset, asynchronous, active-high.
- q_in  in  IN_W  counter value to convert.
- q_vld  in  1  sample strobe; q_in captured on the posedge where q_vld=1 and block idle.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd_tens/bcd_ones update.
- bcd_tens  out  4  tens digit of last completed conversion.
- bcd_ones  out  4  ones digit of last completed conversion.
- seg  out  7  segments, active-high, bit0=a … bit6=g.
- an  out  2  digit enables, active-high; 2'b01 = ones, 2'b10 = tens.

Behaviour:
- Reset (async, rs=1): state=IDLE; busy=0; done=0; bcd_tens=0; bcd_ones=0; seg=7'b0000000; an=2'b01; refresh counter=0; shift counter=0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - On q_vld=1, load shift reg = q_in and clear BCD scratch = 0.
  - Go to SHIFT and set busy=1.
- SHIFT, one iteration per cycle:
  - Any scratch nibble >=5 gets +3.
  - Then {scratch, shift reg} shifts left 1.
  - After IN_W iterations, go to DONE.
- DONE, one cycle:
  - bcd_tens/bcd_ones <= scratch; done=1; busy=0.
  - Next state IDLE.
- Latency: q_vld sampled at edge N -> done=1 and digits valid after edge N+IN_W+1 (6 cycles for IN_W=5).
- Tens digit range 0..3 for IN_W=5; scratch is 8 bits and must not overflow.
- q_vld while busy or in DONE: ignored (see optional feature).
- q_vld in the same cycle as the DONE->IDLE transition is not accepted; it is accepted only from IDLE.
- Output hold: bcd outputs hold their value between conversions.
- Reset mid-conversion: aborts; outputs return to reset values immediately; no done pulse.
- Display mux:
  - Refresh counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, an toggles 01<->10.
  - seg is registered each cycle as seg7_dec(selected digit).
- Leading-zero blank: when an=2'b10 and bcd_tens=0, seg=7'b0000000.
- Digit codes (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Others = 0000000.

Optional Feature:
- Macro: COUNT_BCD_PENDING_EN.
- Defined:
  - One-deep pending slot. q_vld while not IDLE stores q_in in the slot; a later q_vld overwrites it (latest wins).
  - DONE goes straight to SHIFT with the pending value loaded (busy stays 0 only in that DONE cycle), then clears the slot.
  - Reset clears the slot.
- Undefined: q_vld while not IDLE is dropped; no extra registers.

Decomposition:
- Shared package count_disp_pkg holds:
  - FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - Segment code constants SEG_0..SEG_9 and SEG_BLANK.
  - Anode constants AN_ONES, AN_TENS.
- Sub-module seg7_dec: combinational 4-bit digit -> 7-bit segment decoder, instantiated once on the muxed digit.

Test Plan:
- Reset mid-conversion: rs=1, release, q_in=17 q_vld pulse, assert rs two cycles later -> busy=0, done never pulses, bcd_tens=0, bcd_ones=0, seg=0, an=01.
- Max counter value: q_in=20 with a one-cycle q_vld -> done at 6th posedge after sample; bcd_tens=2, bcd_ones=0; while an=10, seg=1011011; while an=01, seg=0111111.
- Single digit: q_in=9 -> tens=0, ones=9; an=10 phase seg=0000000 (blanked); an=01 phase seg=1101111.
- Overlap: q_in=5 strobe, then q_in=12 strobe two cycles later:
  - Without the macro: only 0,5 appears, with one done pulse.
  - With COUNT_BCD_PENDING_EN: done twice, second result 1,2, second done 6 cycles after the first.
- Refresh: REFRESH_DIV=4, idle after reset -> an toggles every 4 cycles (01,01,01,01,10,10,10,10,...).
- Range sweep: drive q_in 0..31 sequentially, waiting for done -> digits equal q_in/10 and q_in%10 for every value, including 31 -> 3,1.
